ps2_rx_frame: RTL and testbench

Front-end PS/2 receiver that feeds the keyboard scan-code decoder. It synchronises and de-glitches the PS/2 clock and data lines, then deframes 11-bit frames: start bit, 8 data bits LSB-first, odd parity, stop bit. It checks parity, stop bit and inter-edge timeout, and buffers good bytes in a small FIFO with a valid/ready interface. The downstream decoder consumes raw scan codes (E0/F0 prefixes included) from this FIFO.

---
 rtl/ps2_rx_frame_pkg.sv | 25 ++
 rtl/ps2_byte_fifo.sv | 61 ++++++
 rtl/ps2_rx_frame.sv | 187 ++++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_frame_pkg.sv
// Shared definitions for the PS/2 receive path.
//   rx_state_e          : deframer FSM states
//   FRAME_BITS          : start + 8 data + parity + stop
//   DATA_BITS           : payload width derived from FRAME_BITS
//   DEFAULT_TIMEOUT_CYC : inter-edge timeout (2 ms at 50 MHz)
//   odd_parity_ok()     : odd-parity check over data and parity bit
package ps2_rx_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam int unsigned FRAME_BITS          = 11;
  localparam int unsigned DATA_BITS           = FRAME_BITS - 3;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 100000;

  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d,
                                         input logic                 p);
    return ^{p, d};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word fall-through byte FIFO, shared by the PS/2 receive and transmit paths.
//   clk, rst : clock, asynchronous active-high reset
//   push_i   : write data_i (accepted when not full, or full with a pop this cycle)
//   data_i   : byte to write
//   pop_i    : consume head entry (ignored when empty)
//   data_o   : head entry, zero when empty
//   full_o   : FIFO holds FIFO_DEPTH entries
//   empty_o  : FIFO holds no entries
module ps2_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == CW'(FIFO_DEPTH));
    do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push = push_i & (~full_o | do_pop);
    data_o  = empty_o ? '0 : mem_q[rd_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: synchronises and de-glitches the PS/2 pins, deframes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop), and buffers good
// bytes in a FWFT FIFO for the scan-code decoder.
//   clk, rst    : system clock, asynchronous active-high reset
//   ps2k_clk    : raw PS/2 clock pin (asynchronous)
//   ps2k_data   : raw PS/2 data pin (asynchronous)
//   byte_data   : FIFO head byte, valid while byte_valid=1
//   byte_valid  : FIFO not empty
//   byte_ready  : consumer takes the head byte this cycle
//   err_parity  : 1-cycle pulse, frame dropped on parity error
//   err_frame   : 1-cycle pulse, stop bit 0 or inter-edge timeout
//   overflow    : 1-cycle pulse, good byte dropped because FIFO full
//   busy        : frame reception in progress
module ps2_rx_frame
  import ps2_rx_frame_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  // Synchronisers (idle-high bus)
  logic clk_s1_q, clk_s2_q;
  logic dat_s1_q, dat_s2_q;

  // Clock filter
  logic [3:0]          fcnt_q;
  logic                filt_q;
  logic                filt_d1_q;
  logic [FILT_LEN-1:0] dly_q;
  logic                fe;
  logic                bit_s;

  // Deframer
  rx_state_e             state_q;
  logic [2:0]            bit_cnt_q;
  logic [DATA_BITS-1:0]  shreg_q;
  logic                  par_q;
  logic [TW-1:0]         tcnt_q;
  logic                  err_parity_q;
  logic                  err_frame_q;
  logic                  ovf_q;

  // FIFO interface
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic stop_eval;
  logic frame_good;
  logic push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2k_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2k_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // The filtered clock flips only after FILT_LEN consecutive differing samples;
  // data runs through an equal-length delay so it stays aligned with fe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q    <= '0;
      filt_q    <= 1'b1;
      filt_d1_q <= 1'b1;
      dly_q     <= '1;
    end else begin
      filt_d1_q <= filt_q;
      dly_q     <= {dly_q[FILT_LEN-2:0], dat_s2_q};
      if (clk_s2_q != filt_q) begin
        if (fcnt_q == 4'(FILT_LEN - 1)) begin
          filt_q <= clk_s2_q;
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + 4'd1;
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  always_comb begin
    fe         = filt_d1_q & ~filt_q;
    bit_s      = dly_q[FILT_LEN-1];
    pop        = ~fifo_empty & byte_ready;
    stop_eval  = fe & (state_q == STOP);
    frame_good = bit_s & odd_parity_ok(shreg_q, par_q);
    push       = stop_eval & frame_good & (~fifo_full | pop);
  end

  // Deframer FSM with inter-edge timeout; fe takes precedence over timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      tcnt_q       <= '0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      ovf_q        <= 1'b0;
      if (fe) begin
        tcnt_q <= '0;
        unique case (state_q)
          IDLE: begin
            if (!bit_s) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shreg_q[bit_cnt_q] <= bit_s;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
            else                   bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          PARITY: begin
            par_q   <= bit_s;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!bit_s)                               err_frame_q  <= 1'b1;
            else if (!odd_parity_ok(shreg_q, par_q))  err_parity_q <= 1'b1;
            else if (fifo_full && !pop)               ovf_q        <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_q     <= IDLE;
          err_frame_q <= 1'b1;
          tcnt_q      <= '0;
        end else begin
          tcnt_q <= tcnt_q + 1'b1;
        end
      end
    end
  end

  ps2_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (shreg_q),
    .pop_i   (byte_ready),
    .data_o  (byte_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    byte_valid = ~fifo_empty;
    err_parity = err_parity_q;
    err_frame  = err_frame_q;
    overflow   = ovf_q;
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
module tb_ps2_rx_frame;

  localparam int unsigned FILT = 4;
  localparam int unsigned TO   = 300;
  localparam int unsigned DEP  = 4;
  localparam int          HP   = 25;   // PS/2 half period in clk cycles

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_par = 0;
  int n_frm = 0;
  int n_ovf = 0;
  int last_ef_cyc = 0;
  int lastfall = 0;

  ps2_rx_frame #(
    .FILT_LEN    (FILT),
    .TIMEOUT_CYC (TO),
    .FIFO_DEPTH  (DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2k_clk   (ps2_clk),
    .ps2k_data  (ps2_data),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (err_parity) n_par <= n_par + 1;
    if (overflow)   n_ovf <= n_ovf + 1;
    if (err_frame) begin
      n_frm       <= n_frm + 1;
      last_ef_cyc <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] d, input logic par, input logic stp);
    return {stp, par, d, 1'b0};
  endfunction

  // Drive the first n bits of a frame. pop_stop pulses byte_ready in the cycle
  // the receiver sees the final falling edge; glitch_idx>=0 adds a 2-cycle low
  // glitch on the clock before that bit's real falling edge.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_stop,
                           input int glitch_idx);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (i == glitch_idx) begin
        tick(4);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(HP/2 - 6);
      end else begin
        tick(HP/2);
      end
      ps2_clk  = 1'b0;
      lastfall = cyc;
      if (pop_stop && i == n - 1) begin
        tick(6);
        byte_ready = 1'b1;
        tick(1);
        byte_ready = 1'b0;
        tick(HP - 7);
      end else begin
        tick(HP);
      end
      ps2_clk = 1'b1;
      tick(HP - HP/2);
    end
    ps2_data = 1'b1;
    tick(HP);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(mkframe(d, ~^d, 1'b1), 11, 1'b0, -1);
  endtask

  task automatic pop_one;
    byte_ready = 1'b1;
    tick(1);
    byte_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; byte_ready = 1'b0;
    tick(3);
    tests++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", byte_valid); end
    tests++; if (byte_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", byte_data); end
    tests++; if ({err_parity, err_frame, overflow} !== 3'b000) begin fails++; $display("FAIL reset_errs got %b exp 000", {err_parity, err_frame, overflow}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_single;
    int p0, f0, o0;
    p0 = n_par; f0 = n_frm; o0 = n_ovf;
    send_byte(8'h1C);
    tests++; if (byte_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", byte_valid); end
    tests++; if (byte_data !== 8'h1C) begin fails++; $display("FAIL single_data got %h exp 1c", byte_data); end
    tests++; if ((n_par - p0) + (n_frm - f0) + (n_ovf - o0) !== 0) begin fails++; $display("FAIL single_errs got %0d exp 0", (n_par - p0) + (n_frm - f0) + (n_ovf - o0)); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b exp 0", busy); end
    pop_one();
    tests++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL single_pop got %b exp 0", byte_valid); end
  endtask

  task automatic test_parity;
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    send_bits(mkframe(8'h1C, 1'b1, 1'b1), 11, 1'b0, -1);
    tests++; if (n_par - p0 !== 1) begin fails++; $display("FAIL parity_pulses got %0d exp 1", n_par - p0); end
    tests++; if (n_frm - f0 !== 0) begin fails++; $display("FAIL parity_frm got %0d exp 0", n_frm - f0); end
    tests++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL parity_valid got %b exp 0", byte_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL parity_busy got %b exp 0", busy); end
  endtask

  task automatic test_timeout;
    int f0, dt;
    f0 = n_frm;
    send_bits(mkframe(8'hF0, 1'b1, 1'b1), 4, 1'b0, -1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL timeout_busy_mid got %b exp 1", busy); end
    tick(TO + 10);
    dt = last_ef_cyc - lastfall;
    tests++; if (n_frm - f0 !== 1) begin fails++; $display("FAIL timeout_pulses got %0d exp 1", n_frm - f0); end
    tests++; if (dt < int'(TO) + 3 || dt > int'(TO) + 10) begin fails++; $display("FAIL timeout_delay got %0d exp %0d..%0d", dt, TO + 3, TO + 10); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy got %b exp 0", busy); end
    tests++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL timeout_valid got %b exp 0", byte_valid); end
    send_bits(mkframe(8'hF0, 1'b1, 1'b1), 11, 1'b0, -1);
    tests++; if (byte_valid !== 1'b1 || byte_data !== 8'hF0) begin fails++; $display("FAIL timeout_next got %b/%h exp 1/f0", byte_valid, byte_data); end
    pop_one();
  endtask

  task automatic test_overflow;
    logic [7:0] exp [5];
    int o0;
    exp[0] = 8'h15; exp[1] = 8'h1D; exp[2] = 8'h24; exp[3] = 8'h2D; exp[4] = 8'h2C;
    o0 = n_ovf;
    for (int i = 0; i < 4; i++) send_byte(exp[i]);
    tests++; if (n_ovf - o0 !== 0) begin fails++; $display("FAIL ovf_early got %0d exp 0", n_ovf - o0); end
    send_byte(exp[4]);
    tests++; if (n_ovf - o0 !== 1) begin fails++; $display("FAIL ovf_pulses got %0d exp 1", n_ovf - o0); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (byte_valid !== 1'b1 || byte_data !== exp[i]) begin
        fails++; $display("FAIL ovf_drain%0d got %b/%h exp 1/%h", i, byte_valid, byte_data, exp[i]);
      end
      pop_one();
    end
    tests++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %b exp 0", byte_valid); end
  endtask

  task automatic test_full_pop;
    logic [7:0] exp [4];
    int o0;
    exp[0] = 8'h1D; exp[1] = 8'h24; exp[2] = 8'h2D; exp[3] = 8'h35;
    send_byte(8'h15);
    for (int i = 0; i < 3; i++) send_byte(exp[i]);
    o0 = n_ovf;
    send_bits(mkframe(8'h35, ~^8'h35, 1'b1), 11, 1'b1, -1);
    tests++; if (n_ovf - o0 !== 0) begin fails++; $display("FAIL fullpop_ovf got %0d exp 0", n_ovf - o0); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (byte_valid !== 1'b1 || byte_data !== exp[i]) begin
        fails++; $display("FAIL fullpop_drain%0d got %b/%h exp 1/%h", i, byte_valid, byte_data, exp[i]);
      end
      pop_one();
    end
    tests++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL fullpop_empty got %b exp 0", byte_valid); end
  endtask

  task automatic test_glitch;
    int p0, f0;
    p0 = n_par; f0 = n_frm;
    send_bits(mkframe(8'h1C, 1'b0, 1'b1), 11, 1'b0, 4);
    tests++; if (byte_valid !== 1'b1 || byte_data !== 8'h1C) begin fails++; $display("FAIL glitch_data got %b/%h exp 1/1c", byte_valid, byte_data); end
    tests++; if ((n_par - p0) + (n_frm - f0) !== 0) begin fails++; $display("FAIL glitch_errs got %0d exp 0", (n_par - p0) + (n_frm - f0)); end
    pop_one();
  endtask

  task automatic test_reset_mid;
    int p0, f0, o0;
    send_byte(8'h2C);
    send_bits(mkframe(8'h1C, 1'b0, 1'b1), 4, 1'b0, -1);
    tests++; if (busy !== 1'b1 || byte_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre got %b/%b exp 1/1", busy, byte_valid); end
    p0 = n_par; f0 = n_frm; o0 = n_ovf;
    #2 rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    tests++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b exp 0", byte_valid); end
    tick(2);
    rst = 1'b0;
    tick(TO + 20);
    tests++; if ((n_par - p0) + (n_frm - f0) + (n_ovf - o0) !== 0) begin fails++; $display("FAIL rstmid_errs got %0d exp 0", (n_par - p0) + (n_frm - f0) + (n_ovf - o0)); end
    tests++; if (busy !== 1'b0 || byte_valid !== 1'b0) begin fails++; $display("FAIL rstmid_after got %b/%b exp 0/0", busy, byte_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_timeout();
    test_overflow();
    test_full_pop();
    test_glitch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
